// File: rtl/gat_feat_reader.sv
// rtl/gat_feat_reader.sv - drains the GAT output-feature BRAM (port B) into a valid/ready stream
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   start, rd_base, rd_count request: first word index and word count (latched in IDLE)
//   busy, done               status: busy while reading, one-cycle done pulse
//   feat_bram_enb/addrb/dout BRAM read port, byte address = word index << 2
//   m_data/m_valid/m_ready   output stream (first-word-fall-through FIFO head)
//   m_last, m_node_last      final word of request / final feature of a node
module gat_feat_reader #(
    parameter int DATA_WIDTH         = 8,
    parameter int NUM_SUBGRAPHS      = 2708,
    parameter int NUM_FEATURE_OUT    = 16,
    parameter int NEW_FEATURE_DEPTH  = NUM_SUBGRAPHS * NUM_FEATURE_OUT,
    parameter int NEW_FEATURE_ADDR_W = $clog2(NEW_FEATURE_DEPTH),
    parameter int RD_LATENCY         = 2,
    parameter int FIFO_DEPTH         = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic [NEW_FEATURE_ADDR_W-1:0] rd_base,
    input  logic [NEW_FEATURE_ADDR_W:0]   rd_count,
    output logic                          busy,
    output logic                          done,
    output logic                          feat_bram_enb,
    output logic [NEW_FEATURE_ADDR_W+1:0] feat_bram_addrb,
    input  logic [31:0]                   feat_bram_dout,
    output logic [DATA_WIDTH-1:0]         m_data,
    output logic                          m_valid,
    input  logic                          m_ready,
    output logic                          m_last,
    output logic                          m_node_last
);
    localparam int AW = NEW_FEATURE_ADDR_W;
    localparam int CW = $clog2(FIFO_DEPTH + RD_LATENCY + 1);
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, FINISH} state_t;

    state_t                 state, state_nx;
    logic [AW-1:0]          idx;
    logic [AW:0]            remaining;
    logic [AW+1:0]          addr_q;
    logic [RD_LATENCY-1:0]  pipe_v, pipe_last, pipe_nl;
    logic [DATA_WIDTH-1:0]  fifo_data [FIFO_DEPTH];
    logic                   fifo_last [FIFO_DEPTH];
    logic                   fifo_nl   [FIFO_DEPTH];
    logic [PW-1:0]          head, tail;
    logic [CW-1:0]          fifo_count, inflight;
    logic                   last_done, issue, push, pop, idx_node_last;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    always_comb begin
        inflight = '0;
        for (int i = 0; i < RD_LATENCY; i++) begin
            inflight = inflight + CW'(pipe_v[i]);
        end
    end

    // Credit rule: every read in flight already owns a FIFO slot, so the FIFO cannot overflow.
    assign issue = (state == ISSUE) && (remaining != '0) &&
                   ((fifo_count + inflight) < CW'(FIFO_DEPTH));
    assign idx_node_last = ((32'(idx) % NUM_FEATURE_OUT) == (NUM_FEATURE_OUT - 1));
    assign push    = pipe_v[RD_LATENCY-1];
    assign m_valid = (fifo_count != '0);
    assign pop     = m_valid & m_ready;

    // Gated so that the stream outputs read 0 whenever the FIFO is empty.
    assign m_data      = m_valid ? fifo_data[head] : '0;
    assign m_last      = m_valid & fifo_last[head];
    assign m_node_last = m_valid & fifo_nl[head];

    always_comb begin
        state_nx        = state;
        busy            = 1'b0;
        done            = 1'b0;
        feat_bram_enb   = issue;
        feat_bram_addrb = issue ? {idx, 2'b00} : addr_q;
        case (state)
            IDLE: begin
                if (start) state_nx = (rd_count != '0) ? ISSUE : FINISH;
            end
            ISSUE: begin
                busy = 1'b1;
                if (issue && (remaining == (AW+1)'(1))) state_nx = DRAIN;
            end
            DRAIN: begin
                busy = 1'b1;
                if ((inflight == '0) && (fifo_count == '0) && last_done) state_nx = FINISH;
            end
            FINISH: begin
                done     = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            idx        <= '0;
            remaining  <= '0;
            addr_q     <= '0;
            pipe_v     <= '0;
            pipe_last  <= '0;
            pipe_nl    <= '0;
            head       <= '0;
            tail       <= '0;
            fifo_count <= '0;
            last_done  <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_data[i] <= '0;
                fifo_last[i] <= 1'b0;
                fifo_nl[i]   <= 1'b0;
            end
        end else begin
            state <= state_nx;
            if ((state == IDLE) && start) begin
                idx       <= rd_base;
                remaining <= rd_count;
                last_done <= 1'b0;
            end else if (issue) begin
                idx       <= (idx == AW'(NEW_FEATURE_DEPTH - 1)) ? '0 : idx + AW'(1);
                remaining <= remaining - (AW+1)'(1);
                addr_q    <= {idx, 2'b00};
            end

            // Valid/tag pipeline mirrors the BRAM read latency; the exiting slot is captured.
            pipe_v[0]    <= issue;
            pipe_last[0] <= issue && (remaining == (AW+1)'(1));
            pipe_nl[0]   <= issue && idx_node_last;
            for (int i = 1; i < RD_LATENCY; i++) begin
                pipe_v[i]    <= pipe_v[i-1];
                pipe_last[i] <= pipe_last[i-1];
                pipe_nl[i]   <= pipe_nl[i-1];
            end

            if (push) begin
                fifo_data[tail] <= feat_bram_dout[DATA_WIDTH-1:0];
                fifo_last[tail] <= pipe_last[RD_LATENCY-1];
                fifo_nl[tail]   <= pipe_nl[RD_LATENCY-1];
                tail            <= ptr_inc(tail);
            end
            if (pop) begin
                head <= ptr_inc(head);
                if (fifo_last[head]) last_done <= 1'b1;
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + CW'(1);
                2'b01:   fifo_count <= fifo_count - CW'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(push && !pop && (fifo_count == CW'(FIFO_DEPTH))));
        end
    end
endmodule

// File: tb/tb_gat_feat_reader.sv
// tb/tb_gat_feat_reader.sv - self-checking bench for gat_feat_reader
module tb_gat_feat_reader;
    localparam int DEPTH = 43328;

    logic        clk, rst, start, busy, done, feat_bram_enb, m_valid, m_ready, m_last, m_node_last;
    logic [15:0] rd_base;
    logic [16:0] rd_count;
    logic [17:0] feat_bram_addrb;
    logic [31:0] feat_bram_dout;
    logic [7:0]  m_data;

    gat_feat_reader dut (
        .clk(clk), .rst(rst), .start(start), .rd_base(rd_base), .rd_count(rd_count),
        .busy(busy), .done(done), .feat_bram_enb(feat_bram_enb), .feat_bram_addrb(feat_bram_addrb),
        .feat_bram_dout(feat_bram_dout), .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
        .m_last(m_last), .m_node_last(m_node_last)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // BRAM model, 2-cycle read latency; upper bits are filler that must not reach m_data.
    function automatic logic [31:0] word_of(input int i);
        logic [31:0] w;
        w = i;
        return {w[15:0] ^ 16'hBEEF, 8'h5A, w[7:0]};
    endfunction
    logic [31:0] r1 = '0, r2 = '0;
    always @(posedge clk) begin
        if (feat_bram_enb) r1 <= word_of(int'(feat_bram_addrb >> 2));
        r2 <= r1;
    end
    assign feat_bram_dout = r2;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int ready_mode = 0;  // 0: always ready, 1: ~30% ready, 2: never ready
    initial begin
        m_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            m_ready = (ready_mode == 0) ? 1'b1 :
                      (ready_mode == 1) ? ($urandom_range(0, 99) < 30) : 1'b0;
        end
    end

    // Monitor, sampled on the falling edge.
    logic        clr = 1'b0;
    logic [7:0]  q_data[$];
    logic        q_last[$], q_nl[$];
    int          q_cyc[$];
    logic [31:0] q_addr[$];
    int done_cnt, done_cyc, first_vcyc, stall_err, credit_err, outstanding;
    bit seen_valid, prev_stall;
    logic [9:0] prev_out;
    always @(negedge clk) begin
        if (clr || rst) begin
            q_data.delete(); q_last.delete(); q_nl.delete(); q_cyc.delete(); q_addr.delete();
            done_cnt = 0; done_cyc = 0; first_vcyc = 0; stall_err = 0; credit_err = 0;
            seen_valid = 0; prev_stall = 0;
            if (rst) outstanding = 0;
        end else begin
            if (m_valid && !seen_valid) begin
                seen_valid = 1;
                first_vcyc = cyc;
            end
            if (prev_stall && (prev_out !== {m_data, m_last, m_node_last})) stall_err++;
            prev_stall = m_valid && !m_ready;
            prev_out   = {m_data, m_last, m_node_last};
            if (feat_bram_enb) begin
                if (outstanding >= 4) credit_err++;
                q_addr.push_back(32'(feat_bram_addrb));
                outstanding++;
            end
            if (m_valid && m_ready) begin
                q_data.push_back(m_data); q_last.push_back(m_last);
                q_nl.push_back(m_node_last); q_cyc.push_back(cyc);
                outstanding--;
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end
    end

    int checks = 0, errors = 0;
    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        clr = 1'b1;
        tick();
        clr = 1'b0;
    endtask

    int start_cyc;
    task automatic do_start(input int base, input int cnt);
        rd_base   = 16'(base);
        rd_count  = 17'(cnt);
        start     = 1'b1;
        start_cyc = cyc;
        tick();
        start = 1'b0;
    endtask

    typedef struct {
        int base; int cnt; int ready_mode; int dup;
        int exp_first; int exp_last; int exp_nl;
    } vec_t;

    task automatic run_vec(input vec_t v);
        bit to;
        int e, seq_err, last_cnt, gaps;
        ready_mode = v.ready_mode;
        clear_mon();
        do_start(v.base, v.cnt);
        to = 1;
        for (int k = 0; k < v.cnt * 8 + 100; k++) begin
            if (done_cnt > 0) begin
                to = 0;
                break;
            end
            if (v.dup > 0 && k == v.dup) begin
                rd_base = 16'd0; rd_count = 17'd5; start = 1'b1;
            end else begin
                start = 1'b0;
            end
            tick();
        end
        start = 1'b0;
        repeat (3) tick();
        check("timeout", to, 0);
        check("beats", q_data.size(), v.cnt);
        check("enb_count", q_addr.size(), v.cnt);
        check("first_data", (q_data.size() > 0) ? q_data[0] : -1, v.exp_first);
        check("last_data", (q_data.size() > 0) ? q_data[q_data.size()-1] : -1, v.exp_last);
        seq_err = 0; last_cnt = 0; gaps = 0; e = 0;
        for (int k = 0; k < q_data.size(); k++) begin
            e = v.base + k;
            if (e >= DEPTH) e -= DEPTH;
            if (q_data[k] != 8'(e) || q_nl[k] != ((e % 16) == 15)) seq_err++;
            if (q_last[k]) last_cnt++;
            if (q_cyc[k] != q_cyc[0] + k) gaps++;
        end
        check("data_sequence_errors", seq_err, 0);
        check("node_last_count", q_nl.sum() with (int'(item)), v.exp_nl);
        check("m_last_count", last_cnt, 1);
        check("m_last_on_final", (q_last.size() > 0) ? q_last[q_last.size()-1] : 0, 1);
        check("done_pulses", done_cnt, 1);
        check("stall_instability", stall_err, 0);
        check("credit_violations", credit_err, 0);
        if (v.ready_mode == 0) begin
            check("first_valid_latency", first_vcyc - start_cyc, 4);
            check("gap_cycles", gaps, 0);
        end
    endtask

    vec_t vecs[5];
    vec_t wrap_v, post_rst_v;
    initial begin
        vecs[0] = '{base: 0,   cnt: 43328, ready_mode: 0, dup: 0, exp_first: 8'h00, exp_last: 8'h3F, exp_nl: 2708};
        vecs[1] = '{base: 32,  cnt: 20,    ready_mode: 1, dup: 0, exp_first: 8'h20, exp_last: 8'h33, exp_nl: 1};
        vecs[2] = '{base: 15,  cnt: 2,     ready_mode: 0, dup: 0, exp_first: 8'h0F, exp_last: 8'h10, exp_nl: 1};
        vecs[3] = '{base: 100, cnt: 1,     ready_mode: 0, dup: 0, exp_first: 8'h64, exp_last: 8'h64, exp_nl: 0};
        vecs[4] = '{base: 200, cnt: 10,    ready_mode: 0, dup: 3, exp_first: 8'hC8, exp_last: 8'hD1, exp_nl: 1};
        wrap_v     = '{base: 43326, cnt: 4, ready_mode: 0, dup: 0, exp_first: 8'h3E, exp_last: 8'h01, exp_nl: 1};
        post_rst_v = '{base: 5,     cnt: 3, ready_mode: 0, dup: 0, exp_first: 8'h05, exp_last: 8'h07, exp_nl: 0};

        rst = 1'b1; start = 1'b0; rd_base = '0; rd_count = '0;
        repeat (3) tick();
        check("reset_outputs", {busy, done, feat_bram_enb, feat_bram_addrb, m_data, m_valid, m_last, m_node_last}, 0);
        rst = 1'b0;
        tick();

        for (int i = 0; i < 5; i++) run_vec(vecs[i]);

        run_vec(wrap_v);
        check("wrap_addr0", (q_addr.size() > 0) ? q_addr[0] : -1, 32'h2A4F8);
        check("wrap_addr1", (q_addr.size() > 1) ? q_addr[1] : -1, 32'h2A4FC);
        check("wrap_addr2", (q_addr.size() > 2) ? q_addr[2] : -1, 32'h0);
        check("wrap_addr3", (q_addr.size() > 3) ? q_addr[3] : -1, 32'h4);

        // Zero-length request.
        ready_mode = 0;
        clear_mon();
        do_start(0, 0);
        repeat (4) tick();
        check("zero_done_pulses", done_cnt, 1);
        check("zero_done_in_window", (done_cyc - start_cyc >= 1) && (done_cyc - start_cyc <= 2), 1);
        check("zero_enb_count", q_addr.size(), 0);
        check("zero_valid_seen", seen_valid, 0);

        // Reset in the middle of a stalled 100-word read.
        ready_mode = 2;
        clear_mon();
        do_start(0, 100);
        repeat (9) tick();
        check("pre_reset_valid", m_valid, 1);
        check("pre_reset_busy", busy, 1);
        rst = 1'b1;
        tick();
        check("mid_reset_outputs", {busy, done, feat_bram_enb, feat_bram_addrb, m_data, m_valid, m_last, m_node_last}, 0);
        rst = 1'b0;
        tick();
        run_vec(post_rst_v);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
